// File: rtl/game_tick_sequencer.sv
// game_tick_sequencer
//   Master scheduler for one game tick. Counts vblank frame pulses, then walks
//   the shared select bus through pacman (0), ghosts 1-4 (1..4) and painter (5),
//   waiting for each stage's done handshake (or a timeout) before moving on.
//   Also owns the edible-ghost countdown loaded by a powerball.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   game_status    0 attract, 1 running, 2 won, 3 lost
//   frame_tick     one-cycle pulse per vblank
//   stage_done     done from the selected stage (level or pulse)
//   power_eaten    one-cycle pulse when pacman eats a powerball
//   select         active stage, 7 = none
//   stage_start    pulse on the first cycle a stage is selected
//   busy           high from the first stage issue through tick completion
//   tick_complete  pulse when the painter stage finishes
//   tick_count     completed game ticks (wrapping)
//   timeout_err    sticky: some stage timed out
//   ghosts_edible  edible countdown is nonzero
//   edible_warn    edible countdown is in 1..8 (ghost flashing)
module game_tick_sequencer #(
  parameter int TICK_FRAMES  = 8,
  parameter int TIMEOUT      = 255,
  parameter int EDIBLE_TICKS = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  game_status,
  input  logic        frame_tick,
  input  logic        stage_done,
  input  logic        power_eaten,
  output logic [2:0]  select,
  output logic        stage_start,
  output logic        busy,
  output logic        tick_complete,
  output logic [15:0] tick_count,
  output logic        timeout_err,
  output logic        ghosts_edible,
  output logic        edible_warn
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAMES,
    ISSUE,
    WAIT_DONE,
    COMPLETE
  } state_t;

  localparam logic [7:0] FRAME_LAST  = 8'(TICK_FRAMES - 1);
  localparam logic [9:0] TMO_LAST    = 10'(TIMEOUT - 1);
  localparam logic [7:0] EDIBLE_LOAD = 8'(EDIBLE_TICKS);
  localparam logic [2:0] LAST_STAGE  = 3'd5;
  localparam logic [2:0] SEL_NONE    = 3'd7;
  localparam logic [1:0] RUNNING     = 2'd1;

  state_t      state, state_nxt;
  logic [7:0]  frame_cnt, frame_cnt_nxt;
  logic [2:0]  stage, stage_nxt;
  logic [9:0]  tmo_cnt, tmo_cnt_nxt;
  logic        err_set;
  logic [7:0]  edible_cnt;
  logic [15:0] tick_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      stage       <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
      edible_cnt  <= '0;
      tick_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      frame_cnt   <= frame_cnt_nxt;
      stage       <= stage_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      timeout_err <= timeout_err | err_set;
      if (state == COMPLETE)
        tick_cnt <= tick_cnt + 16'd1;
      // A powerball load takes priority over the per-tick decrement.
      if (power_eaten)
        edible_cnt <= EDIBLE_LOAD;
      else if (state == COMPLETE && edible_cnt != 8'd0)
        edible_cnt <= edible_cnt - 8'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    stage_nxt     = stage;
    tmo_cnt_nxt   = tmo_cnt;
    err_set       = 1'b0;
    case (state)
      IDLE: begin
        frame_cnt_nxt = '0;
        if (game_status == RUNNING)
          state_nxt = WAIT_FRAMES;
      end
      WAIT_FRAMES: begin
        if (game_status != RUNNING) begin
          state_nxt     = IDLE;
          frame_cnt_nxt = '0;
        end else if (frame_tick) begin
          if (frame_cnt == FRAME_LAST) begin
            frame_cnt_nxt = '0;
            stage_nxt     = '0;
            state_nxt     = ISSUE;
          end else begin
            frame_cnt_nxt = frame_cnt + 8'd1;
          end
        end
      end
      ISSUE: begin
        // stage_done is deliberately ignored here so a stale level from the
        // previous stage cannot complete the new one.
        tmo_cnt_nxt = '0;
        state_nxt   = WAIT_DONE;
      end
      WAIT_DONE: begin
        tmo_cnt_nxt = tmo_cnt + 10'd1;
        // Exit on the cycle the counter would reach TIMEOUT; done on that
        // same cycle wins and suppresses the error.
        if (stage_done || tmo_cnt == TMO_LAST) begin
          err_set = ~stage_done;
          if (stage == LAST_STAGE) begin
            state_nxt = COMPLETE;
          end else begin
            stage_nxt = stage + 3'd1;
            state_nxt = ISSUE;
          end
        end
      end
      COMPLETE: begin
        frame_cnt_nxt = '0;
        state_nxt     = (game_status == RUNNING) ? WAIT_FRAMES : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  assign select        = (state == ISSUE || state == WAIT_DONE) ? stage : SEL_NONE;
  assign stage_start   = (state == ISSUE);
  assign busy          = (state == ISSUE || state == WAIT_DONE || state == COMPLETE);
  assign tick_complete = (state == COMPLETE);
  assign tick_count    = tick_cnt;
  assign ghosts_edible = (edible_cnt != 8'd0);
  assign edible_warn   = (edible_cnt != 8'd0) && (edible_cnt <= 8'd8);

endmodule

// File: tb/tb_game_tick_sequencer.sv
module tb_game_tick_sequencer;

  localparam int TF = 2;
  localparam int TO = 5;
  localparam int ET = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  game_status = 2'd0;
  logic        frame_tick;
  logic        stage_done;
  logic        power_eaten = 1'b0;
  logic [2:0]  select;
  logic        stage_start;
  logic        busy;
  logic        tick_complete;
  logic [15:0] tick_count;
  logic        timeout_err;
  logic        ghosts_edible;
  logic        edible_warn;

  logic ft_manual = 1'b0;
  logic ft_spam   = 1'b0;
  logic auto_d    = 1'b0;
  logic hold_d    = 1'b0;
  assign frame_tick = ft_manual | ft_spam;
  assign stage_done = auto_d | hold_d;

  game_tick_sequencer #(
    .TICK_FRAMES (TF),
    .TIMEOUT     (TO),
    .EDIBLE_TICKS(ET)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .game_status  (game_status),
    .frame_tick   (frame_tick),
    .stage_done   (stage_done),
    .power_eaten  (power_eaten),
    .select       (select),
    .stage_start  (stage_start),
    .busy         (busy),
    .tick_complete(tick_complete),
    .tick_count   (tick_count),
    .timeout_err  (timeout_err),
    .ghosts_edible(ghosts_edible),
    .edible_warn  (edible_warn)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          cmpl;
    logic [2:0]  sel;
    int          gap;
    logic [15:0] tc;
    logic        err;
    logic        ed;
    logic        warn;
  } ev_t;

  ev_t sb[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;

  int  m_ticks = 0;
  bit  m_err = 1'b0;
  int  m_cnt = 0;

  bit         auto_en = 1'b1;
  logic [2:0] hang_stage = 3'd7;
  bit         spam_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stage responder: done pulse two cycles after each stage_start.
  initial begin
    forever begin
      @(negedge clk);
      if (stage_start === 1'b1 && auto_en && select !== hang_stage) begin
        @(posedge clk);
        @(posedge clk);
        #1 auto_d = 1'b1;
        @(posedge clk);
        #1 auto_d = 1'b0;
      end
    end
  end

  // Background frame pulses every third cycle while enabled.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      ft_spam = spam_en && (k % 3 == 0);
      k++;
    end
  end

  // Monitor: every stage_start / tick_complete pops one expected event.
  ev_t me;
  int  last_cyc = 0;
  int  ev_idx = 0;
  always @(negedge clk) begin
    if (reset === 1'b0 && (stage_start === 1'b1 || tick_complete === 1'b1)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: select=%0d stage_start=%0b tick_complete=%0b, expected no activity",
                 select, stage_start, tick_complete);
      end else begin
        me = sb.pop_front();
        chk($sformatf("ev%0d_kind", ev_idx), {31'd0, tick_complete}, {31'd0, me.cmpl});
        chk($sformatf("ev%0d_sel", ev_idx), {29'd0, select}, {29'd0, me.sel});
        chk($sformatf("ev%0d_busy", ev_idx), {31'd0, busy}, 32'd1);
        chk($sformatf("ev%0d_tick_count", ev_idx), {16'd0, tick_count}, {16'd0, me.tc});
        chk($sformatf("ev%0d_timeout_err", ev_idx), {31'd0, timeout_err}, {31'd0, me.err});
        chk($sformatf("ev%0d_edible", ev_idx), {31'd0, ghosts_edible}, {31'd0, me.ed});
        chk($sformatf("ev%0d_warn", ev_idx), {31'd0, edible_warn}, {31'd0, me.warn});
        if (me.gap != 0)
          chk($sformatf("ev%0d_gap", ev_idx), cyc - last_cyc, me.gap);
      end
      ev_idx++;
      last_cyc = cyc;
    end
  end

  function automatic int slen(input int s, input int hang, input bit held);
    if (held) return 2;
    return (s == hang) ? 1 + TO : 3;
  endfunction

  task automatic push_tick(input int hang, input bit held, input bit reload);
    ev_t e;
    for (int s = 0; s < 6; s++) begin
      e.cmpl = 1'b0;
      e.sel  = 3'(s);
      e.gap  = (s == 0) ? 0 : slen(s - 1, hang, held);
      e.tc   = 16'(m_ticks);
      e.err  = m_err || (hang < s);
      e.ed   = (m_cnt != 0);
      e.warn = (m_cnt != 0) && (m_cnt <= 8);
      sb.push_back(e);
    end
    e.cmpl = 1'b1;
    e.sel  = 3'd7;
    e.gap  = slen(5, hang, held);
    e.tc   = 16'(m_ticks);
    e.err  = m_err || (hang <= 5);
    e.ed   = (m_cnt != 0);
    e.warn = (m_cnt != 0) && (m_cnt <= 8);
    sb.push_back(e);
    m_ticks = (m_ticks + 1) & 16'hFFFF;
    if (hang <= 5) m_err = 1'b1;
    if (reload) m_cnt = ET;
    else if (m_cnt > 0) m_cnt = m_cnt - 1;
  endtask

  task automatic pulse_frame();
    ft_manual = 1'b1;
    tick(1);
    ft_manual = 1'b0;
  endtask

  task automatic launch(input int hang, input bit held, input bit reload, input int nframes);
    hang_stage = 3'(hang);
    auto_en    = !held;
    hold_d     = held;
    push_tick(hang, held, reload);
    if (nframes == 2) begin
      pulse_frame();
      tick(2);
      chk("no_start_after_one_frame", {29'd0, select}, 32'd7);
    end
    pulse_frame();
    chk("start_select", {29'd0, select}, 32'd0);
    chk("start_pulse", {31'd0, stage_start}, 32'd1);
  endtask

  task automatic wait_empty(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      tick(1);
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d events still pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_sel(input logic [2:0] v, input int budget, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (select === v) begin
        got = 1'b1;
        break;
      end
      tick(1);
    end
    chk(name, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_cmpl_pe(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick_complete === 1'b1) begin
        power_eaten = 1'b1;
        @(posedge clk);
        #1 power_eaten = 1'b0;
        got = 1'b1;
        break;
      end
    end
    chk("complete_seen_for_reload", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    chk("rst_select", {29'd0, select}, 32'd7);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stage_start", {31'd0, stage_start}, 32'd0);
    chk("rst_tick_complete", {31'd0, tick_complete}, 32'd0);
    chk("rst_tick_count", {16'd0, tick_count}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_edible", {31'd0, ghosts_edible}, 32'd0);
    chk("rst_warn", {31'd0, edible_warn}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Nominal tick
    game_status = 2'd1;
    tick(2);
    launch(7, 1'b0, 1'b0, 2);
    wait_empty(100, "nominal");
    chk("nominal_tick_count", {16'd0, tick_count}, 32'd1);
    chk("nominal_no_err", {31'd0, timeout_err}, 32'd0);
    chk("nominal_idle_busy", {31'd0, busy}, 32'd0);

    // Timeout on stage 2
    launch(2, 1'b0, 1'b0, 2);
    wait_empty(100, "timeout");
    chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    hang_stage = 3'd7;

    // Done held high, frame pulses during the sequence are dropped
    launch(7, 1'b1, 1'b0, 2);
    spam_en = 1'b1;
    wait_sel(3'd5, 40, "held_reach_stage5");
    spam_en = 1'b0;
    wait_empty(40, "held");
    hold_d  = 1'b0;
    auto_en = 1'b1;
    chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
    tick(2);
    pulse_frame();
    tick(3);
    chk("frame_cnt_restart_select", {29'd0, select}, 32'd7);
    chk("frame_cnt_restart_busy", {31'd0, busy}, 32'd0);

    // Status change mid-sequence; second frame of this tick
    launch(7, 1'b0, 1'b0, 1);
    spam_en = 1'b1;
    wait_sel(3'd3, 40, "status_reach_stage3");
    game_status = 2'd2;
    wait_empty(60, "status_change");
    tick(20);
    spam_en = 1'b0;
    tick(2);
    chk("idle_select", {29'd0, select}, 32'd7);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Powerball while idle
    power_eaten = 1'b1;
    tick(1);
    power_eaten = 1'b0;
    m_cnt = ET;
    chk("idle_power_edible", {31'd0, ghosts_edible}, 32'd1);
    chk("idle_power_warn", {31'd0, edible_warn}, 32'd0);
    game_status = 2'd1;
    tick(2);

    // Edible countdown over 11 ticks
    for (int t = 0; t < 11; t++) begin
      launch(7, 1'b0, 1'b0, 2);
      wait_empty(100, "edible");
    end
    chk("edible_expired", {31'd0, ghosts_edible}, 32'd0);
    power_eaten = 1'b1;
    tick(1);
    power_eaten = 1'b0;
    m_cnt = ET;
    chk("reload_edible", {31'd0, ghosts_edible}, 32'd1);
    for (int t = 0; t < 7; t++) begin
      launch(7, 1'b0, 1'b0, 2);
      wait_empty(100, "edible2");
    end
    chk("warn_before_reload", {31'd0, edible_warn}, 32'd1);
    launch(7, 1'b0, 1'b1, 2);
    wait_cmpl_pe(100);
    wait_empty(20, "reload_tick");
    chk("reload_wins_edible", {31'd0, ghosts_edible}, 32'd1);
    chk("reload_wins_warn", {31'd0, edible_warn}, 32'd0);
    launch(7, 1'b0, 1'b0, 2);
    wait_empty(100, "after_reload");

    // Reset during stage 4
    launch(7, 1'b0, 1'b0, 2);
    wait_sel(3'd4, 40, "reach_stage4");
    reset = 1'b1;
    tick(1);
    sb.delete();
    m_ticks = 0;
    m_err   = 1'b0;
    m_cnt   = 0;
    chk("midrst_select", {29'd0, select}, 32'd7);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("midrst_tick_count", {16'd0, tick_count}, 32'd0);
    chk("midrst_tick_complete", {31'd0, tick_complete}, 32'd0);
    chk("midrst_edible", {31'd0, ghosts_edible}, 32'd0);
    reset = 1'b0;
    tick(10);
    chk("post_rst_select", {29'd0, select}, 32'd7);
    chk("post_rst_tick_count", {16'd0, tick_count}, 32'd0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
